// File: rtl/video_timinggen.sv
// Video timing generator with test-pattern source.
// Produces sync, active and colour outputs one clock after the raster counters.
module video_timinggen #(
  parameter int unsigned H_SYNC   = 40,
  parameter int unsigned H_BACKP  = 220,
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned H_TOTAL  = 1650,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BACKP  = 20,
  parameter int unsigned V_ACTIVE = 720,
  parameter int unsigned V_TOTAL  = 750
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [23:0] fill_color,
  output logic        active_out,
  output logic [7:0]  r_out,
  output logic [7:0]  g_out,
  output logic [7:0]  b_out,
  output logic        hsyncn_out,
  output logic        vsyncn_out,
  output logic        frame_top
);

  localparam int unsigned H_W     = 11;
  localparam int unsigned V_W     = 10;
  localparam int unsigned H_START = H_SYNC + H_BACKP;
  localparam int unsigned H_END   = H_START + H_ACTIVE;
  localparam int unsigned V_START = V_SYNC + V_BACKP;
  localparam int unsigned V_END   = V_START + V_ACTIVE;

  logic           en_meta;
  logic           run;
  logic [H_W-1:0] hcount;
  logic [V_W-1:0] vcount;

  logic [H_W-1:0] hx;
  logic [5:0]     vy_lo;
  logic           h_act;
  logic           v_act;
  logic           act_c;
  logic [23:0]    rgb_c;

  function automatic logic [23:0] bar_color(input logic [3:0] band);
    logic [23:0] c;
    c = 24'h000000;
    case (band)
      4'd0: c = 24'hFFFFFF;
      4'd1: c = 24'hFFFF00;
      4'd2: c = 24'h00FFFF;
      4'd3: c = 24'h00FF00;
      4'd4: c = 24'hFF00FF;
      4'd5: c = 24'hFF0000;
      4'd6: c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

  // Two-flop synchronizer for the asynchronous run request
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_meta <= 1'b0;
      run     <= 1'b0;
    end else begin
      en_meta <= enable;
      run     <= en_meta;
    end
  end

  // Raster counters; held at the origin whenever run is low
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcount <= '0;
      vcount <= '0;
    end else if (!run) begin
      hcount <= '0;
      vcount <= '0;
    end else if (hcount == H_W'(H_TOTAL - 1)) begin
      hcount <= '0;
      vcount <= (vcount == V_W'(V_TOTAL - 1)) ? '0 : vcount + V_W'(1);
    end else begin
      hcount <= hcount + H_W'(1);
    end
  end

  assign hx    = hcount - H_W'(H_START);
  assign vy_lo = 6'(vcount - V_W'(V_START));
  assign h_act = (hcount >= H_W'(H_START)) && (hcount < H_W'(H_END));
  assign v_act = (vcount >= V_W'(V_START)) && (vcount < V_W'(V_END));
  assign act_c = h_act && v_act;

  always_comb begin
    rgb_c = 24'h000000;
    if (act_c) begin
      case (pattern_sel)
        2'd0:    rgb_c = bar_color(hx[10:7]);
        2'd1:    rgb_c = fill_color;
        2'd2:    rgb_c = {3{hx[7:0]}};
        default: rgb_c = ((hx[5:0] == 6'd0) || (vy_lo == 6'd0)) ? 24'hFFFFFF : fill_color;
      endcase
    end
  end

  // Output register: idle whenever run is low, otherwise decoded from the counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_out <= 1'b0;
      hsyncn_out <= 1'b1;
      vsyncn_out <= 1'b1;
      frame_top  <= 1'b0;
      r_out      <= 8'h00;
      g_out      <= 8'h00;
      b_out      <= 8'h00;
    end else if (!run) begin
      active_out <= 1'b0;
      hsyncn_out <= 1'b1;
      vsyncn_out <= 1'b1;
      frame_top  <= 1'b0;
      r_out      <= 8'h00;
      g_out      <= 8'h00;
      b_out      <= 8'h00;
    end else begin
      active_out <= act_c;
      hsyncn_out <= (hcount >= H_W'(H_SYNC));
      vsyncn_out <= (vcount >= V_W'(V_SYNC));
      frame_top  <= (hcount == '0) && (vcount == '0);
      r_out      <= rgb_c[23:16];
      g_out      <= rgb_c[15:8];
      b_out      <= rgb_c[7:0];
    end
  end

endmodule

// File: tb/tb_video_timinggen.sv
// Directed bench for video_timinggen: default horizontal timing, shortened frame height.
module tb_video_timinggen;

  localparam int unsigned HT     = 1650;
  localparam int unsigned VT     = 12;
  localparam int unsigned FRAME  = HT * VT;
  localparam int unsigned DROP_R = 8 * HT + 800;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic [23:0] fill_color;
  logic        active_out;
  logic [7:0]  r_out;
  logic [7:0]  g_out;
  logic [7:0]  b_out;
  logic        hsyncn_out;
  logic        vsyncn_out;
  logic        frame_top;

  int n_checks;
  int n_errors;
  int hs_low;
  int vs_low;
  int act_n;
  int ft_n;
  int bad;
  int solid_act;

  video_timinggen #(
    .H_SYNC(40), .H_BACKP(220), .H_ACTIVE(1280), .H_TOTAL(1650),
    .V_SYNC(2), .V_BACKP(3), .V_ACTIVE(4), .V_TOTAL(12)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .pattern_sel(pattern_sel),
    .fill_color(fill_color),
    .active_out(active_out),
    .r_out(r_out),
    .g_out(g_out),
    .b_out(b_out),
    .hsyncn_out(hsyncn_out),
    .vsyncn_out(vsyncn_out),
    .frame_top(frame_top)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rgb();
    return 32'({r_out, g_out, b_out});
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_act"}, 32'(active_out), 32'd0);
    check({tag, "_hs"},  32'(hsyncn_out), 32'd1);
    check({tag, "_vs"},  32'(vsyncn_out), 32'd1);
    check({tag, "_ft"},  32'(frame_top),  32'd0);
    check({tag, "_rgb"}, rgb(),           32'h000000);
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    hs_low = 0; vs_low = 0; act_n = 0; ft_n = 0; bad = 0; solid_act = 0;
    reset_n = 1'b0; enable = 1'b1; pattern_sel = 2'd0; fill_color = 24'h000000;
    repeat (3) step();
    check_idle("rst");

    // Release reset with enable held: hsync first low after the third edge
    @(negedge clk); reset_n = 1'b1;
    step(); check("pre1_hs", 32'(hsyncn_out), 32'd1);
    step(); check("pre2_hs", 32'(hsyncn_out), 32'd1);
    check("pre2_ft", 32'(frame_top), 32'd0);
    step();
    check("p0_hs", 32'(hsyncn_out), 32'd0);
    check("p0_vs", 32'(vsyncn_out), 32'd0);
    check("p0_ft", 32'(frame_top), 32'd1);

    // Frame 1: colour bars, timing statistics
    for (int p = 0; p < int'(FRAME); p++) begin
      if (p > 0) step();
      if (!hsyncn_out) hs_low++;
      if (!vsyncn_out) vs_low++;
      if (active_out)  act_n++;
      if (frame_top)   ft_n++;
      case (p)
        39:    check("hs_last_low", 32'(hsyncn_out), 32'd0);
        40:    check("hs_first_high", 32'(hsyncn_out), 32'd1);
        1650:  check("line_period_hs", 32'(hsyncn_out), 32'd0);
        3299:  check("vs_last_low", 32'(vsyncn_out), 32'd0);
        3300:  check("vs_first_high", 32'(vsyncn_out), 32'd1);
        8509:  check("pre_active", 32'(active_out), 32'd0);
        8510: begin
          check("first_active", 32'(active_out), 32'd1);
          check("bar_white", rgb(), 32'hFFFFFF);
        end
        8670:  check("bar_yellow", rgb(), 32'hFFFF00);
        9630: begin
          check("bar8_active", 32'(active_out), 32'd1);
          check("bar8_black", rgb(), 32'h000000);
        end
        14739: check("last_active", 32'(active_out), 32'd1);
        14740: begin
          check("post_active", 32'(active_out), 32'd0);
          check("post_active_rgb", rgb(), 32'h000000);
        end
        15110: check("line9_blank", 32'(active_out), 32'd0);
        default: ;
      endcase
    end
    check("hs_low_count", 32'(hs_low), 32'd480);
    check("vs_low_count", 32'(vs_low), 32'd3300);
    check("active_count", 32'(act_n),  32'd5120);
    check("ft_count",     32'(ft_n),   32'd1);

    step();
    check("ft_period", 32'(frame_top), 32'd1);
    check("f2_hs", 32'(hsyncn_out), 32'd0);
    check("f2_vs", 32'(vsyncn_out), 32'd0);

    // Frame 2: ramp and crosshatch, patterns switched during blanking
    for (int q = 1; q < int'(FRAME); q++) begin
      step();
      case (q)
        8250:  pattern_sel = 2'd2;
        8810:  check("ramp_300", rgb(), 32'h2C2C2C);
        9900: begin
          pattern_sel = 2'd3;
          fill_color  = 24'h123456;
        end
        10160: check("xh_hx0", rgb(), 32'hFFFFFF);
        10224: check("xh_hx64", rgb(), 32'hFFFFFF);
        10225: check("xh_hx65", rgb(), 32'h123456);
        10230: check("xh_hx70", rgb(), 32'h123456);
        14850: pattern_sel = 2'd1;
        default: ;
      endcase
    end

    // Frame 3: solid fill on every active pixel, zero elsewhere
    step();
    check("f3_ft", 32'(frame_top), 32'd1);
    for (int r = 1; r <= int'(DROP_R); r++) begin
      int  line;
      int  h;
      logic ea;
      step();
      line = r / int'(HT);
      h    = r % int'(HT);
      ea   = (line >= 5) && (line < 9) && (h >= 260) && (h < 1540);
      if (ea) solid_act++;
      if ((active_out !== ea) || (rgb() !== (ea ? 32'h123456 : 32'h0))) bad++;
    end
    check("solid_bad_pixels", 32'(bad), 32'd0);
    check("solid_active_seen", 32'(solid_act), 32'd4381);

    // Drop enable mid-line, then re-raise
    enable = 1'b0;
    repeat (4) step();
    check_idle("drop");
    repeat (5) step();
    check_idle("drop_hold");
    enable = 1'b1;
    step(); step();
    check("rr_pre_hs", 32'(hsyncn_out), 32'd1);
    check("rr_pre_ft", 32'(frame_top), 32'd0);
    step();
    check("rr_ft", 32'(frame_top), 32'd1);
    check("rr_hs", 32'(hsyncn_out), 32'd0);
    check("rr_vs", 32'(vsyncn_out), 32'd0);

    // Asynchronous reset in the middle of an active pixel run
    repeat (8520) step();
    check("arst_pre_act", 32'(active_out), 32'd1);
    check("arst_pre_rgb", rgb(), 32'h123456);
    #2 reset_n = 1'b0;
    #1;
    check_idle("arst");
    repeat (2) step();
    check_idle("arst_hold");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
